ex_mem_reg: RTL and testbench



---
 rtl/ex_mem_reg_pkg.sv | 24 ++
 rtl/ex_mem_reg_pipe_dff.sv | 27 ++
 rtl/ex_mem_reg.sv | 72 +++++++
 tb/tb_ex_mem_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
// ============================================================================
//  Module  : ex_mem_reg_pkg
//  Brief   : Shared pipeline constants and control-bundle type.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package ex_mem_reg_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Control bits that travel down the pipe to the MEM and WB stages.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } mem_wb_ctrl_t;

    localparam int CTRL_W = $bits(mem_wb_ctrl_t);

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg_pipe_dff.sv
// ============================================================================
//  Module  : pipe_dff
//  Brief   : Parameterized-width pipeline flop, async active-high reset to 0.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module pipe_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ============================================================================
//  Module  : ex_mem_reg
//  Brief   : EX/MEM pipeline register; unconditional one-cycle capture.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int XLEN       = ex_mem_reg_pkg::XLEN,
    parameter int REG_ADDR_W = ex_mem_reg_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic                  MemWrite,
    input  logic [XLEN-1:0]       AluResult,
    input  logic [XLEN-1:0]       Datain,
    input  logic [REG_ADDR_W-1:0] Rd_in,
    output logic                  RegWrite_Out,
    output logic                  MemtoReg_Out,
    output logic                  MemWrite_Out,
    output logic [XLEN-1:0]       AluOut,
    output logic [XLEN-1:0]       DataOut,
    output logic [REG_ADDR_W-1:0] Rd_out
);

    mem_wb_ctrl_t ctrl_d;
    mem_wb_ctrl_t ctrl_q;

    assign ctrl_d.reg_write  = RegWrite;
    assign ctrl_d.mem_to_reg = MemtoReg;
    assign ctrl_d.mem_write  = MemWrite;

    // Control bits clear on reset, so a reset bubble never commits a write.
    pipe_dff #(.WIDTH(CTRL_W)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_dff #(.WIDTH(XLEN)) u_alu (
        .clk   (clk),
        .reset (reset),
        .d     (AluResult),
        .q     (AluOut)
    );

    pipe_dff #(.WIDTH(XLEN)) u_data (
        .clk   (clk),
        .reset (reset),
        .d     (Datain),
        .q     (DataOut)
    );

    pipe_dff #(.WIDTH(REG_ADDR_W)) u_rd (
        .clk   (clk),
        .reset (reset),
        .d     (Rd_in),
        .q     (Rd_out)
    );

    assign RegWrite_Out = ctrl_q.reg_write;
    assign MemtoReg_Out = ctrl_q.mem_to_reg;
    assign MemWrite_Out = ctrl_q.mem_write;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
// ============================================================================
//  Module  : tb_ex_mem_reg
//  Brief   : Self-checking bench for ex_mem_reg (vector table + scoreboard).
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_reg;

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic [63:0] alu;
        logic [63:0] din;
        logic [4:0]  rd;
    } vec_t;

    typedef struct packed {
        vec_t in;
        vec_t exp;
    } tv_t;

    localparam int NVEC = 10;

    logic        clk;
    logic        reset;
    logic        RegWrite, MemtoReg, MemWrite;
    logic [63:0] AluResult, Datain;
    logic [4:0]  Rd_in;
    logic        RegWrite_Out, MemtoReg_Out, MemWrite_Out;
    logic [63:0] AluOut, DataOut;
    logic [4:0]  Rd_out;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t last_exp;
    tv_t  tv [NVEC];

    ex_mem_reg dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .MemWrite     (MemWrite),
        .AluResult    (AluResult),
        .Datain       (Datain),
        .Rd_in        (Rd_in),
        .RegWrite_Out (RegWrite_Out),
        .MemtoReg_Out (MemtoReg_Out),
        .MemWrite_Out (MemWrite_Out),
        .AluOut       (AluOut),
        .DataOut      (DataOut),
        .Rd_out       (Rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t outs();
        vec_t v;
        v.rw  = RegWrite_Out;
        v.mr  = MemtoReg_Out;
        v.mw  = MemWrite_Out;
        v.alu = AluOut;
        v.din = DataOut;
        v.rd  = Rd_out;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.rw  = 1'($urandom);
        v.mr  = 1'($urandom);
        v.mw  = 1'($urandom);
        v.alu = {$urandom, $urandom};
        v.din = {$urandom, $urandom};
        v.rd  = 5'($urandom);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        RegWrite  = v.rw;
        MemtoReg  = v.mr;
        MemWrite  = v.mw;
        AluResult = v.alu;
        Datain    = v.din;
        Rd_in     = v.rd;
    endtask

    task automatic check(input string name, input vec_t exp);
        vec_t act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rw=%b mr=%b mw=%b alu=%h din=%h rd=%0d, want rw=%b mr=%b mw=%b alu=%h din=%h rd=%0d",
                     name, act.rw, act.mr, act.mw, act.alu, act.din, act.rd,
                     exp.rw, exp.mr, exp.mw, exp.alu, exp.din, exp.rd);
        end
    endtask

    // Wait for the capturing edge, then compare against the oldest pending entry.
    task automatic edge_check(input string name);
        vec_t exp;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h want queued entry", name, outs());
        end else begin
            exp = sb.pop_front();
            check(name, exp);
            last_exp = exp;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t zero, v;
        zero = '0;

        for (int i = 0; i < NVEC; i++) begin
            tv[i].in  = rand_vec();
            tv[i].exp = tv[i].in;
        end
        tv[0].in  = '1;
        tv[0].exp = {1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31};
        tv[1].in  = {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h0, 5'd0};
        tv[1].exp = {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h0, 5'd0};

        // Reset asserted from time zero with busy inputs.
        reset = 1'b1;
        apply({1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h1, 5'd7});
        #1;
        check("reset_before_edge", zero);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", zero);
        end
        last_exp = zero;

        // Release between edges, then capture all-zero inputs.
        #2;
        reset = 1'b0;
        apply(zero);
        sb.push_back(zero);
        edge_check("zero_capture");

        v = {1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31};
        #2;
        apply(v);
        sb.push_back({1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31});
        #1;
        check("hold_before_edge", zero);
        edge_check("basic_capture");

        // Table: glitch inputs mid-cycle, settle, then capture.
        for (int i = 0; i < NVEC; i++) begin
            #2;
            apply(rand_vec());
            #1;
            apply(tv[i].in);
            sb.push_back(tv[i].exp);
            check("table_hold", last_exp);
            edge_check("table_capture");
        end

        // Asynchronous reset 3 units after an edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", zero);
        sb.delete();
        v = {1'b1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5'd19};
        apply(v);
        @(posedge clk);
        #1;
        check("reset_ignores_edge", zero);
        #2;
        reset = 1'b0;
        #1;
        check("release_hold", zero);
        sb.push_back({1'b1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5'd19});
        edge_check("post_reset_capture");

        // Rd=0 and sign bit pass through untouched.
        #2;
        apply({1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 5'd0});
        sb.push_back({1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 5'd0});
        edge_check("rd0_sign");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
